axis_join_rr: RTL

// - Order-restoring merge of two AXI-Stream lanes back into one stream; consumes the two outputs of the alternating fork stage.
// - Strict alternation: takes one beat from s01, then one from s00, and so on, so the original beat order is rebuilt exactly.
// - Per-lane 2-entry skid buffers and a registered output sustain 1 beat/cycle.
// - A sticky watchdog flags a lane that starves the alternation.
//

---
 rtl/axis_join_rr_pkg.sv | 29 ++
 rtl/axis_join_rr_skid_fifo2.sv | 72 +++++++
 rtl/axis_join_rr.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axis_join_rr_pkg.sv
// -----------------------------------------------------------------------------
// axis_join_rr_pkg
//
// Purpose : Shared definitions for the alternating fork/join AXI-Stream pair.
//           The lane-select encoding must match the fork stage bit for bit.
//           PHASE_S01 (1'b0) names lane s01, which carries the 1st, 3rd, ... beat.
//           PHASE_S00 (1'b1) names lane s00, which carries the 2nd, 4th, ... beat.
//
// Contents: phase_e      - lane-select phase encoding
//           SKID_DEPTH   - entries per lane skid buffer
//           wait_width() - width of the watchdog stall counter for a timeout
// -----------------------------------------------------------------------------
package axis_join_rr_pkg;

  typedef enum logic {
    PHASE_S01 = 1'b0,
    PHASE_S00 = 1'b1
  } phase_e;

  localparam int SKID_DEPTH = 2;

  // The stall counter has to hold the value TIMEOUT itself, because it
  // saturates there. A disabled watchdog (timeout 0) still gets one bit so
  // that no declaration has zero width.
  function automatic int wait_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/axis_join_rr_skid_fifo2.sv
// -----------------------------------------------------------------------------
// axis_skid_fifo2
//
// Purpose : A 2-entry FIFO that sits in front of one join lane. It accepts a
//           beat on every cycle unless both entries are occupied. A push and a
//           pop may occur in the same cycle: at count 1 the count stays the
//           same, and at count 0 only the push takes effect.
//
// Ports   : clk       in   clock
//           rst       in   synchronous active-high reset
//           i_tvalid  in   upstream valid
//           i_tdata   in   upstream data [DATA_WD]
//           o_tready  out  upstream ready; = !rst && (count != 2)
//           o_tvalid  out  FIFO non-empty (head valid)
//           o_tdata   out  head-of-FIFO data [DATA_WD]
//           i_pop     in   consume head; ignored while empty
// -----------------------------------------------------------------------------
module axis_skid_fifo2
  import axis_join_rr_pkg::*;
#(
  parameter int DATA_WD = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tvalid,
  input  logic [DATA_WD-1:0] i_tdata,
  output logic               o_tready,
  output logic               o_tvalid,
  output logic [DATA_WD-1:0] o_tdata,
  input  logic               i_pop
);

  logic [DATA_WD-1:0] r_mem [SKID_DEPTH];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;

  logic               w_push;
  logic               w_pop;

  // Ready is qualified with rst so that no beat can be accepted (and lost)
  // during the reset cycle.
  assign o_tready = !rst && (r_count != 2'd2);
  assign w_push   = i_tvalid && o_tready;
  assign w_pop    = i_pop && (r_count != 2'd0);

  assign o_tvalid = (r_count != 2'd0);
  assign o_tdata  = r_mem[r_rd_ptr];

  // NOTE: every register written on a clock edge uses non-blocking '<='.
  // As a result, all blocks see the pre-edge values of one another.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (w_pop && !w_push) r_count <= r_count - 2'd1;
    end
  end

  // NOTE: the storage array has no reset. r_count alone decides whether an
  // entry is valid, so stale contents are never observed. Leaving the array
  // unreset also keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_tdata;
  end

endmodule

// File: rtl/axis_join_rr.sv
// -----------------------------------------------------------------------------
// axis_join_rr
//
// Purpose : Order-restoring merge of the two lanes produced by the alternating
//           fork stage. Beats are taken strictly in turn: first s01, then s00,
//           then s01 again, and so on. This rebuilds the original beat order.
//           Each lane has a 2-entry skid buffer, and the output is registered,
//           so alternating traffic sustains one beat per cycle. A sticky
//           watchdog raises order_err when the selected lane starves the
//           alternation while the other lane is holding data.
//
// Parameters: DATA_WD  tdata width
//             CNT_WD   width of the delivered-beat counter
//             TIMEOUT  stall cycles before order_err sets; 0 disables it
//
// Ports   : clk              in   clock
//           rst              in   synchronous active-high reset
//           s00_axis_tvalid  in   lane 00 valid (2nd, 4th, ... beats)
//           s00_axis_tdata   in   lane 00 data
//           s00_axis_tready  out  lane 00 ready
//           s01_axis_tvalid  in   lane 01 valid (1st, 3rd, ... beats)
//           s01_axis_tdata   in   lane 01 data
//           s01_axis_tready  out  lane 01 ready
//           m_axis_tvalid    out  merged valid (registered)
//           m_axis_tdata     out  merged data (registered)
//           m_axis_tready    in   merged ready
//           beat_cnt         out  beats delivered on m_axis, wraps
//           order_err        out  sticky watchdog flag, cleared only by rst
// -----------------------------------------------------------------------------
module axis_join_rr
  import axis_join_rr_pkg::*;
#(
  parameter int DATA_WD = 64,
  parameter int CNT_WD  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s00_axis_tvalid,
  input  logic [DATA_WD-1:0] s00_axis_tdata,
  output logic               s00_axis_tready,
  input  logic               s01_axis_tvalid,
  input  logic [DATA_WD-1:0] s01_axis_tdata,
  output logic               s01_axis_tready,
  output logic               m_axis_tvalid,
  output logic [DATA_WD-1:0] m_axis_tdata,
  input  logic               m_axis_tready,
  output logic [CNT_WD-1:0]  beat_cnt,
  output logic               order_err
);

  localparam int WAIT_WD = wait_width(TIMEOUT);

  // Lane buffer heads
  logic               w_s00_valid;
  logic [DATA_WD-1:0] w_s00_data;
  logic               w_s01_valid;
  logic [DATA_WD-1:0] w_s01_data;
  logic               w_pop_s00;
  logic               w_pop_s01;

  // Selection and output control
  phase_e             r_phase;
  phase_e             w_phase_nxt;
  logic               w_out_free;
  logic               w_sel_nonempty;
  logic               w_other_nonempty;
  logic [DATA_WD-1:0] w_sel_data;
  logic               w_load_en;

  logic               r_m_tvalid;
  logic [DATA_WD-1:0] r_m_tdata;
  logic [CNT_WD-1:0]  r_beat_cnt;

  // ---------------------------------------------------------------------------
  // Per-lane skid buffers
  // ---------------------------------------------------------------------------
  axis_skid_fifo2 #(.DATA_WD(DATA_WD)) u_skid_s00 (
    .clk      (clk),
    .rst      (rst),
    .i_tvalid (s00_axis_tvalid),
    .i_tdata  (s00_axis_tdata),
    .o_tready (s00_axis_tready),
    .o_tvalid (w_s00_valid),
    .o_tdata  (w_s00_data),
    .i_pop    (w_pop_s00)
  );

  axis_skid_fifo2 #(.DATA_WD(DATA_WD)) u_skid_s01 (
    .clk      (clk),
    .rst      (rst),
    .i_tvalid (s01_axis_tvalid),
    .i_tdata  (s01_axis_tdata),
    .o_tready (s01_axis_tready),
    .o_tvalid (w_s01_valid),
    .o_tdata  (w_s01_data),
    .i_pop    (w_pop_s01)
  );

  // ---------------------------------------------------------------------------
  // Lane selection. Only the lane named by the phase can be drained. The other
  // lane waits even while the output is idle, because draining it early would
  // reorder the stream.
  // ---------------------------------------------------------------------------
  assign w_out_free       = !r_m_tvalid || m_axis_tready;
  assign w_sel_nonempty   = (r_phase == PHASE_S00) ? w_s00_valid : w_s01_valid;
  assign w_other_nonempty = (r_phase == PHASE_S00) ? w_s01_valid : w_s00_valid;
  assign w_sel_data       = (r_phase == PHASE_S00) ? w_s00_data  : w_s01_data;
  assign w_load_en        = w_out_free && w_sel_nonempty;

  // NOTE: each signal driven from always_comb receives a default value first.
  // A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    w_phase_nxt = r_phase;
    w_pop_s00   = 1'b0;
    w_pop_s01   = 1'b0;
    if (w_load_en) begin
      if (r_phase == PHASE_S00) begin
        w_pop_s00   = 1'b1;
        w_phase_nxt = PHASE_S01;
      end else begin
        w_pop_s01   = 1'b1;
        w_phase_nxt = PHASE_S00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_phase <= PHASE_S01;
    else     r_phase <= w_phase_nxt;
  end

  // ---------------------------------------------------------------------------
  // Registered output stage. When the slot is free and the selected lane has
  // nothing to offer, valid is withdrawn rather than held.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
    end else if (w_out_free) begin
      r_m_tvalid <= w_sel_nonempty;
      if (w_sel_nonempty) r_m_tdata <= w_sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                             r_beat_cnt <= '0;
    else if (r_m_tvalid && m_axis_tready) r_beat_cnt <= r_beat_cnt + CNT_WD'(1);
  end

  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign beat_cnt      = r_beat_cnt;

  // ---------------------------------------------------------------------------
  // Watchdog. Stall cycles are counted only while the other lane is holding
  // data. An empty other lane means the traffic has simply paused, which is
  // not an ordering hazard, so it clears the count.
  // ---------------------------------------------------------------------------
  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam logic [WAIT_WD-1:0] TIMEOUT_W = WAIT_WD'(TIMEOUT);

      logic [WAIT_WD-1:0] r_wait_cnt;
      logic               r_order_err;
      logic               w_starve;

      assign w_starve = w_out_free && !w_sel_nonempty && w_other_nonempty;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_wait_cnt  <= '0;
          r_order_err <= 1'b0;
        end else begin
          if (w_load_en || !w_other_nonempty)
            r_wait_cnt <= '0;
          else if (w_starve && (r_wait_cnt != TIMEOUT_W))
            r_wait_cnt <= r_wait_cnt + WAIT_WD'(1);

          if (r_wait_cnt == TIMEOUT_W) r_order_err <= 1'b1;
        end
      end

      assign order_err = r_order_err;
    end else begin : g_no_wdog
      assign order_err = 1'b0;
    end
  endgenerate

endmodule
